alu_seq: RTL
============

Name: alu_seq

Overview:
Sequential 8-bit ALU that sits directly upstream of the accumulator register and produces its next value. It takes the current accumulator value and an operand, and computes one of eight operations. It drives the accumulator's data input (acc_in) and its load enable (en_da) as registered outputs. Most operations take one cycle; MUL is an 8-step shift-add. Carry and zero flags are registered for the control unit.

Parameters:
W, 8, datapath width. Only 8 is supported in v1.
MUL_STEPS, 8, number of shift-add iterations. Must equal W.

Ports:
clk  input  1  system clock, rising edge
clr  input  1  asynchronous active-low reset
start  input  1  request an operation; sampled only in IDLE
op  input  3  opcode, captured with start
acc_q  input  8  current accumulator value (accumulator output)
opnd  input  8  second operand, captured with start
acc_in  output  8  result to the accumulator data input; registered
en_da  output  1  one-cycle load strobe to the accumulator; registered
busy  output  1  high while not IDLE
c_flag  output  1  registered carry/overflow flag
z_flag  output  1  registered zero flag

Behaviour:
- Reset: clr low asynchronously forces the following, regardless of clk:
  - state=IDLE
  - acc_in=0x00, en_da=0, busy=0, c_flag=0, z_flag=0
  - internal product/count/operand registers cleared
- Reset in the middle of an operation aborts it; no en_da pulse is produced.
- States: IDLE, MUL, WB. busy = (state != IDLE).
- IDLE, start=1 at edge E0:
  - acc_q, opnd and op are latched.
  - If op != MUL: acc_in <= result, flags updated, en_da <= 1, go to WB.
  - If op == MUL: clear product and count, go to MUL.
- MUL: one shift-add step per edge, E1..E8.
  - At E8: acc_in <= product[7:0], c_flag <= |product[15:8], z_flag <= (product[7:0]==0), en_da <= 1, go to WB.
- WB: lasts one cycle. At the next edge: en_da <= 0, go to IDLE.
- Latency: single-cycle ops have en_da high in the cycle after E0, and the accumulator loads at E1. MUL has en_da high after E8, and the accumulator loads at E9.
- start while busy (MUL or WB) is ignored, not queued.
  - The earliest next accepted start is the first edge after returning to IDLE.
  - This guarantees the next operation sees the updated acc_q.
- Opcodes (A = latched acc_q, B = latched opnd):
  - 000 LOAD: B; c unchanged
  - 001 ADD: A+B mod 256; c = carry out
  - 010 SUB: A-B mod 256; c = 1 when A>=B (no borrow), else 0
  - 011 AND: A&B; c=0
  - 100 OR: A|B; c=0
  - 101 XOR: A^B; c=0
  - 110 SHL: A<<1; c = A[7]
  - 111 MUL: A*B low byte; c = high byte nonzero
- z_flag = (result == 0) for every op.
- Flags change only at the edge that sets en_da. Otherwise they hold.
- acc_in holds its last result after en_da drops.
- Changes on acc_q/opnd/op after capture have no effect.

Test Plan:
- Reset: clr low with start high → all outputs 0. Release clr, no start → en_da stays 0 for 20 cycles.
- ADD: acc_q=0xF0, opnd=0x20, op=001, start for 1 cycle → en_da=1 for exactly 1 cycle (cycle after start), acc_in=0x10, c=1, z=0; busy high that cycle only.
- SUB: acc_q=0x05, opnd=0x07, op=010 → acc_in=0xFE, c=0, z=0. Then acc_q=0x07, opnd=0x07 → acc_in=0x00, c=1, z=1.
- MUL: acc_q=0x12, opnd=0x10, op=111 → busy for 9 cycles, en_da only in cycle 9, acc_in=0x20, c=1. Then 0x0F*0x03 → acc_in=0x2D, c=0.
- Start while busy: during MUL, pulse start with op=000, opnd=0xAA at cycles 3 and 9 → ignored; only the MUL result is written. Start in the cycle after WB is accepted.
- Reset mid-MUL: clr low at cycle 4 of MUL → immediate IDLE, outputs 0, no en_da. After release, LOAD 0x5A → acc_in=0x5A, z=0.

Source files
------------

// File: rtl/alu_seq_if.sv
// Handshake/bus bundle between the control side and the sequential ALU.
// Latency: n/a (wires only).
// Backpressure: none; busy tells the master that start will be ignored.
//   master: drives start/op/acc_q/opnd, observes acc_in/en_da/busy/flags
//   slave : the ALU itself
interface alu_seq_if #(
    parameter int W = 8
);
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] acc_q;
    logic [W-1:0] opnd;
    logic [W-1:0] acc_in;
    logic         en_da;
    logic         busy;
    logic         c_flag;
    logic         z_flag;

    modport master (
        output start, op, acc_q, opnd,
        input  acc_in, en_da, busy, c_flag, z_flag
    );

    modport slave (
        input  start, op, acc_q, opnd,
        output acc_in, en_da, busy, c_flag, z_flag
    );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU computing the accumulator's next value (acc_in) plus carry/zero flags.
// Latency: single-cycle ops strobe en_da the cycle after start; MUL strobes it after 8 shift-add steps.
// Backpressure: start is only sampled in IDLE; while busy it is dropped, never queued.
//   i_clk   : system clock, rising edge
//   i_clr   : asynchronous active-low reset
//   io_bus  : slave side of alu_seq_if (start/op/acc_q/opnd in, acc_in/en_da/busy/c_flag/z_flag out)
module alu_seq #(
    parameter int W         = 8,
    parameter int MUL_STEPS = 8   // must equal W: one step per multiplier bit
) (
    input  logic        i_clk,
    input  logic        i_clr,
    alu_seq_if.slave    io_bus
);

    localparam int CNT_W = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_WB   = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        OP_LOAD = 3'd0,
        OP_ADD  = 3'd1,
        OP_SUB  = 3'd2,
        OP_AND  = 3'd3,
        OP_OR   = 3'd4,
        OP_XOR  = 3'd5,
        OP_SHL  = 3'd6,
        OP_MUL  = 3'd7
    } op_e;

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_e           r_state;
    logic [W-1:0]     r_acc_in;
    logic             r_en_da;
    logic             r_busy;
    logic             r_c;
    logic             r_z;

    // Multiplier working registers. The multiplicand is held at double width
    // and shifted left each step; the multiplier is shifted right so that
    // bit 0 always selects whether this step adds.
    logic [2*W-1:0]   r_prod;
    logic [2*W-1:0]   r_mcand;
    logic [W-1:0]     r_mplier;
    logic [CNT_W-1:0] r_cnt;

    // ------------------------------------------------------------------
    // Single-cycle datapath, evaluated directly on the captured inputs
    // ------------------------------------------------------------------
    logic [W:0]       w_sum;
    logic [W:0]       w_diff;
    logic [W-1:0]     w_res;
    logic             w_c;

    always_comb begin
        w_sum  = {1'b0, io_bus.acc_q} + {1'b0, io_bus.opnd};
        w_diff = {1'b0, io_bus.acc_q} - {1'b0, io_bus.opnd};
        w_res  = '0;
        w_c    = r_c;
        case (op_e'(io_bus.op))
            OP_LOAD: begin
                w_res = io_bus.opnd;
                w_c   = r_c;            // LOAD leaves carry untouched
            end
            OP_ADD: begin
                w_res = w_sum[W-1:0];
                w_c   = w_sum[W];
            end
            OP_SUB: begin
                w_res = w_diff[W-1:0];
                w_c   = ~w_diff[W];     // carry means "no borrow", i.e. A >= B
            end
            OP_AND: begin
                w_res = io_bus.acc_q & io_bus.opnd;
                w_c   = 1'b0;
            end
            OP_OR: begin
                w_res = io_bus.acc_q | io_bus.opnd;
                w_c   = 1'b0;
            end
            OP_XOR: begin
                w_res = io_bus.acc_q ^ io_bus.opnd;
                w_c   = 1'b0;
            end
            OP_SHL: begin
                w_res = {io_bus.acc_q[W-2:0], 1'b0};
                w_c   = io_bus.acc_q[W-1];
            end
            OP_MUL: begin
                // Handled by the iterative path; nothing written here.
                w_res = '0;
                w_c   = r_c;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shift-add step
    // ------------------------------------------------------------------
    logic [2*W-1:0]   w_prod_nxt;
    logic             w_mul_last;

    always_comb begin
        w_prod_nxt = r_mplier[0] ? (r_prod + r_mcand) : r_prod;
        w_mul_last = (r_cnt == CNT_W'(MUL_STEPS - 1));
    end

    // ------------------------------------------------------------------
    // Controller: single sequential block, all outputs registered
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_clr) begin
        if (!i_clr) begin
            r_state  <= ST_IDLE;
            r_acc_in <= '0;
            r_en_da  <= 1'b0;
            r_busy   <= 1'b0;
            r_c      <= 1'b0;
            r_z      <= 1'b0;
            r_prod   <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (io_bus.start) begin
                        r_busy <= 1'b1;
                        if (op_e'(io_bus.op) == OP_MUL) begin
                            r_prod   <= '0;
                            r_cnt    <= '0;
                            r_mcand  <= {{W{1'b0}}, io_bus.acc_q};
                            r_mplier <= io_bus.opnd;
                            r_state  <= ST_MUL;
                        end else begin
                            r_acc_in <= w_res;
                            r_c      <= w_c;
                            r_z      <= (w_res == '0);
                            r_en_da  <= 1'b1;
                            r_state  <= ST_WB;
                        end
                    end
                end

                ST_MUL: begin
                    r_prod   <= w_prod_nxt;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    // The last step writes back straight from the adder output
                    // so the result lands on the same edge as the final add.
                    if (w_mul_last) begin
                        r_acc_in <= w_prod_nxt[W-1:0];
                        r_c      <= |w_prod_nxt[2*W-1:W];
                        r_z      <= (w_prod_nxt[W-1:0] == '0);
                        r_en_da  <= 1'b1;
                        r_state  <= ST_WB;
                    end
                end

                ST_WB: begin
                    r_en_da <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_en_da <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign io_bus.acc_in = r_acc_in;
    assign io_bus.en_da  = r_en_da;
    assign io_bus.busy   = r_busy;
    assign io_bus.c_flag = r_c;
    assign io_bus.z_flag = r_z;

endmodule
